// File: rtl/cnn_pkg.sv
// Shared constants and FSM state type for the CNN custom-instruction issue controller.
// Used by cnn_issue_ctrl and cnn_timeout_cnt.
package cnn_pkg;

   localparam logic [6:0]  OP_CNN             = 7'b0101011;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
   localparam logic [31:0] ERR_DATA_DEF       = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WB,
      ST_DONE
   } state_t;

endpackage

// File: rtl/cnn_timeout_cnt.sv
// Accelerator watchdog: cleared on issue, counts ISSUE/WAIT cycles, flags expiry on the LIMIT-th cycle.
// Only instantiated when CNN_ISSUE_TIMEOUT_EN is defined.
module cnn_timeout_cnt
   import cnn_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds (cycles already spent - 1), so this fires on the LIMIT-th enabled cycle
   assign expire = en & (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/cnn_issue_ctrl.sv
// Stalls the pipeline, hands a decoded CNN op to the accelerator and writes its result back; min 4 cycles detect-to-release.
// Define CNN_ISSUE_TIMEOUT_EN to add the accelerator watchdog (abort pulse, ERR_DATA writeback, sticky err).
module cnn_issue_ctrl
   import cnn_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  Op,
   input  logic        InstrValidD,
   input  logic [2:0]  funct3D,
   input  logic [31:0] RD1D,
   input  logic [31:0] RD2D,
   input  logic [4:0]  RdD,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushD,
   output logic        FlushE,
   output logic        acc_req,
   output logic [2:0]  acc_op,
   output logic [31:0] acc_a,
   output logic [31:0] acc_b,
   input  logic        acc_ack,
   input  logic        acc_done,
   input  logic [31:0] acc_result,
   output logic        acc_abort,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   input  logic        wb_ready,
   output logic        busy,
   output logic        err
);

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;

   logic detect;
   logic running;
   logic done_ok;
   logic expire_w;
   logic abort_w;

   assign detect  = (state_q == ST_IDLE) & InstrValidD & (Op == OP_CNN);
   assign running = (state_q == ST_ISSUE) | (state_q == ST_WAIT);
   // a result only counts once the command has been accepted
   assign done_ok = acc_done & (((state_q == ST_ISSUE) & acc_ack) | (state_q == ST_WAIT));
   assign abort_w = expire_w & ~done_ok;

`ifdef CNN_ISSUE_TIMEOUT_EN
   cnn_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (detect),
      .en     (running),
      .expire (expire_w)
   );
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
   assign expire_w = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rd_d    = rd_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (detect) begin
               op_d    = funct3D;
               a_d     = RD1D;
               b_d     = RD2D;
               rd_d    = RdD;
               data_d  = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE, ST_WAIT: begin
            if (done_ok) begin
               data_d  = acc_result;
               state_d = ST_WB;
            end else if (abort_w) begin
               data_d  = ERR_DATA;
               err_d   = 1'b1;
               state_d = ST_WB;
            end else if ((state_q == ST_ISSUE) && acc_ack) begin
               state_d = ST_WAIT;
            end
         end
         ST_WB: begin
            // x0 writes are dropped, so there is no handshake to wait for
            if ((rd_q == 5'd0) || wb_ready) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      acc_req   = 1'b0;
      acc_op    = '0;
      acc_a     = '0;
      acc_b     = '0;
      wb_valid  = 1'b0;
      wb_rd     = '0;
      wb_data   = '0;
      busy      = (state_q != ST_IDLE);
      err       = err_q;
      acc_abort = abort_w;
      case (state_q)
         ST_IDLE: begin
            StallF = detect;
            StallD = detect;
            FlushE = detect;
         end
         ST_ISSUE: begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            FlushE  = 1'b1;
            acc_req = 1'b1;
            acc_op  = op_q;
            acc_a   = a_q;
            acc_b   = b_q;
         end
         ST_WAIT: begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
         ST_WB: begin
            StallF   = 1'b1;
            StallD   = 1'b1;
            FlushE   = 1'b1;
            wb_valid = (rd_q != 5'd0);
            wb_rd    = rd_q;
            wb_data  = data_q;
         end
         ST_DONE: begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cnn_issue_ctrl.sv
// Directed bench for cnn_issue_ctrl; timeout scenarios compile in when CNN_ISSUE_TIMEOUT_EN is defined.
module tb_cnn_issue_ctrl;
   import cnn_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  Op;
   logic        InstrValidD;
   logic [2:0]  funct3D;
   logic [31:0] RD1D, RD2D;
   logic [4:0]  RdD;
   logic        StallF, StallD, FlushD, FlushE;
   logic        acc_req;
   logic [2:0]  acc_op;
   logic [31:0] acc_a, acc_b;
   logic        acc_ack, acc_done;
   logic [31:0] acc_result;
   logic        acc_abort;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_ready;
   logic        busy, err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cnn_issue_ctrl #(
      .TIMEOUT_CYCLES (8),
      .ERR_DATA       (32'hFFFF_FFFF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .Op          (Op),
      .InstrValidD (InstrValidD),
      .funct3D     (funct3D),
      .RD1D        (RD1D),
      .RD2D        (RD2D),
      .RdD         (RdD),
      .StallF      (StallF),
      .StallD      (StallD),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .acc_req     (acc_req),
      .acc_op      (acc_op),
      .acc_a       (acc_a),
      .acc_b       (acc_b),
      .acc_ack     (acc_ack),
      .acc_done    (acc_done),
      .acc_result  (acc_result),
      .acc_abort   (acc_abort),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .wb_ready    (wb_ready),
      .busy        (busy),
      .err         (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic issue_cmd(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      Op          = OP_CNN;
      InstrValidD = 1'b1;
      funct3D     = fn;
      RD1D        = a;
      RD2D        = b;
      RdD         = rd;
   endtask

   initial begin
      rst = 1'b0;
      Op = '0; InstrValidD = 1'b0; funct3D = '0; RD1D = '0; RD2D = '0; RdD = '0;
      acc_ack = 1'b0; acc_done = 1'b0; acc_result = '0; wb_ready = 1'b0;
      cyc; cyc;
      chk("rst_busy", busy, 0);
      chk("rst_stall", {StallF, StallD, FlushD, FlushE}, 0);
      chk("rst_acc", {acc_req, acc_abort, wb_valid, err}, 0);
      chk("rst_accab", acc_a | acc_b | wb_data, 0);
      rst = 1'b1;
      cyc;

      // Wrong opcode must not trigger
      Op = 7'b0110011; InstrValidD = 1'b1;
      #1 chk("bad_op_stall", {StallF, StallD, FlushE}, 0);
      cyc;
      InstrValidD = 1'b0;

      // Basic flow: ack at N+1, done (35) at N+3, ready immediately
      issue_cmd(3'd2, 32'd5, 32'd7, 5'd3);
      #1 chk("t1_detect_stall", {StallF, StallD, FlushE, FlushD}, 4'b1110);
      chk("t1_detect_busy", busy, 0);
      cyc;
      acc_ack = 1'b1;
      #1 chk("t1_issue_req", acc_req, 1);
      chk("t1_issue_op", acc_op, 2);
      chk("t1_issue_a", acc_a, 5);
      chk("t1_issue_b", acc_b, 7);
      chk("t1_issue_stall", {StallF, StallD, FlushE}, 3'b111);
      cyc;
      acc_ack = 1'b0;
      #1 chk("t1_wait_req", acc_req, 0);
      chk("t1_wait_stall", {StallF, StallD, busy}, 3'b111);
      cyc;
      acc_done = 1'b1; acc_result = 32'd35;
      #1 chk("t1_wait2_wbv", wb_valid, 0);
      cyc;
      acc_done = 1'b0; wb_ready = 1'b1; InstrValidD = 1'b0;
      #1 chk("t1_wb_valid", wb_valid, 1);
      chk("t1_wb_rd", wb_rd, 3);
      chk("t1_wb_data", wb_data, 35);
      chk("t1_wb_stall", StallD, 1);
      cyc;
      wb_ready = 1'b0;
      #1 chk("t1_done_flush", {FlushD, FlushE}, 2'b11);
      chk("t1_done_stall", {StallF, StallD, wb_valid}, 0);
      cyc;
      #1 chk("t1_idle", {busy, FlushD, FlushE, StallD}, 0);

      // Ack withheld 4 cycles, then ack+done together, then wb_ready held low 3 cycles
      issue_cmd(3'd5, 32'h1234_5678, 32'hABCD_0001, 5'd7);
      cyc;
      InstrValidD = 1'b0; RD1D = 32'hDEAD_BEEF; RD2D = 32'h0BAD_F00D;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t2_hold_req", acc_req, 1);
         chk("t2_hold_a", acc_a, 32'h1234_5678);
         chk("t2_hold_b", acc_b, 32'hABCD_0001);
         cyc;
      end
      acc_ack = 1'b1; acc_done = 1'b1; acc_result = 32'h55;
      #1 chk("t2_still_issue", acc_op, 5);
      cyc;
      acc_ack = 1'b0; acc_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t2_wb_valid", wb_valid, 1);
         chk("t2_wb_data", wb_data, 32'h55);
         chk("t2_wb_rd", wb_rd, 7);
         chk("t2_wb_stall", StallD, 1);
         cyc;
      end
      wb_ready = 1'b1;
      #1 chk("t2_wb_last", wb_valid, 1);
      cyc;
      wb_ready = 1'b0;
      #1 chk("t2_done", {FlushD, StallD}, 2'b10);
      cyc;

      // Destination x0: no writeback request, still completes without wb_ready
      issue_cmd(3'd1, 32'd3, 32'd3, 5'd0);
      cyc;
      InstrValidD = 1'b0; acc_ack = 1'b1; acc_done = 1'b1; acc_result = 32'd9;
      cyc;
      acc_ack = 1'b0; acc_done = 1'b0;
      #1 chk("t3_wb_novalid", wb_valid, 0);
      chk("t3_wb_stall", StallD, 1);
      cyc;
      #1 chk("t3_done", {FlushD, StallD, wb_valid}, 3'b100);
      cyc;
      #1 chk("t3_idle", busy, 0);

      // Async reset while waiting on the accelerator
      issue_cmd(3'd3, 32'd1, 32'd2, 5'd9);
      cyc;
      InstrValidD = 1'b0; acc_ack = 1'b1;
      cyc;
      acc_ack = 1'b0;
      #1 chk("t4_wait_busy", busy, 1);
      rst = 1'b0;
      #1 chk("t4_rst_busy", busy, 0);
      chk("t4_rst_out", {StallD, StallF, acc_req, FlushE, acc_abort}, 0);
      cyc;
      acc_done = 1'b1; acc_result = 32'h99;
      rst = 1'b1;
      #1 chk("t4_late_done_busy", busy, 0);
      cyc;
      acc_done = 1'b0;
      #1 chk("t4_late_done_wb", {busy, wb_valid, wb_data[7:0]}, 0);

`ifdef CNN_ISSUE_TIMEOUT_EN
      // No result: abort on the 8th ISSUE/WAIT cycle
      issue_cmd(3'd4, 32'd8, 32'd8, 5'd4);
      cyc;
      InstrValidD = 1'b0; acc_ack = 1'b1;
      #1 chk("t5_abort_c1", acc_abort, 0);
      cyc;
      acc_ack = 1'b0;
      for (int i = 2; i <= 7; i++) begin
         #1 chk("t5_abort_early", acc_abort, 0);
         cyc;
      end
      #1 chk("t5_abort_pulse", acc_abort, 1);
      cyc;
      #1 chk("t5_wb_err_data", wb_data, 32'hFFFF_FFFF);
      chk("t5_err", {err, acc_abort, wb_valid}, 3'b101);
      wb_ready = 1'b1;
      cyc;
      wb_ready = 1'b0;
      cyc;
      #1 chk("t5_err_sticky", {err, busy}, 2'b10);
      rst = 1'b0;
      #1 chk("t5_err_rst", err, 0);
      cyc;
      rst = 1'b1;
      // Result arrives on the expiry cycle: result wins
      issue_cmd(3'd4, 32'd8, 32'd8, 5'd4);
      cyc;
      InstrValidD = 1'b0; acc_ack = 1'b1;
      cyc;
      acc_ack = 1'b0;
      for (int i = 2; i <= 7; i++) cyc;
      acc_done = 1'b1; acc_result = 32'h77;
      #1 chk("t6_no_abort", acc_abort, 0);
      cyc;
      acc_done = 1'b0;
      #1 chk("t6_wb_data", wb_data, 32'h77);
      chk("t6_err", err, 0);
      wb_ready = 1'b1;
      cyc;
      wb_ready = 1'b0;
      cyc;
`else
      // Without the watchdog a long wait never aborts
      issue_cmd(3'd4, 32'd8, 32'd8, 5'd4);
      cyc;
      InstrValidD = 1'b0; acc_ack = 1'b1;
      cyc;
      acc_ack = 1'b0;
      for (int i = 0; i < 12; i++) begin
         #1 chk("t5_no_abort", {acc_abort, err, busy}, 3'b001);
         cyc;
      end
      acc_done = 1'b1; acc_result = 32'h77;
      cyc;
      acc_done = 1'b0;
      #1 chk("t5_wb_data", wb_data, 32'h77);
      chk("t5_err", err, 0);
      wb_ready = 1'b1;
      cyc;
      wb_ready = 1'b0;
      cyc;
`endif
      #1 chk("final_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cnn_issue_ctrl.md
CNN_ISSUE_CTRL -- requirements
Module: cnn_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max cycles in ISSUE+WAIT before abort (timeout build only).
REQ-002 Parameter ERR_DATA, default 32'hFFFF_FFFF, writeback value on timeout.
REQ-003 clk  in  1  single clock; all state rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 Op  in  7  decode-stage opcode.
REQ-006 InstrValidD  in  1  decode-stage instruction valid.
REQ-007 funct3D  in  3  CNN sub-operation.
REQ-008 RD1D, RD2D  in  32 each  decode-stage source operands.
REQ-009 RdD  in  5  destination register.
REQ-010 StallF, StallD  out  1  fetch/decode stall.
REQ-011 FlushD, FlushE  out  1  decode/execute bubble insert.
REQ-012 acc_req  out  1; acc_op  out  3; acc_a, acc_b  out  32: accelerator command.
REQ-013 acc_ack  in  1  command accepted; acc_done  in  1  result valid; acc_result  in  32.
REQ-014 acc_abort  out  1  one-cycle abort pulse.
REQ-015 wb_valid  out  1; wb_rd  out  5; wb_data  out  32; wb_ready  in  1: register-file write port request.
REQ-016 busy  out  1 (state != IDLE); err  out  1 sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, WB, DONE.
REQ-018 detect = InstrValidD & (Op == 7'b0101011); SHALL be evaluated only in IDLE.
REQ-019 IDLE & detect: capture funct3D, RD1D, RD2D, RdD; next state ISSUE; StallF=StallD=1 combinationally same cycle.
REQ-020 StallF=StallD=1 in ISSUE, WAIT, WB; FlushE=1 in IDLE-with-detect, ISSUE, WAIT, WB, DONE.
REQ-021 ISSUE: acc_req=1, acc_op/acc_a/acc_b driven from captured regs, stable until acc_ack; acc_ack -> WAIT.
REQ-022 ISSUE with acc_ack & acc_done same cycle: capture acc_result, go WB directly.
REQ-023 WAIT: acc_done -> capture acc_result into wb_data, go WB; acc_done outside ISSUE/WAIT SHALL be ignored.
REQ-024 WB: wb_valid=1, wb_rd/wb_data stable until wb_ready; wb_valid & wb_ready -> DONE.
REQ-025 WB with captured rd == 0: wb_valid SHALL stay 0; go DONE next cycle.
REQ-026 DONE: one cycle, StallF=StallD=0, FlushD=1, FlushE=1 (squash the custom instruction in decode); next IDLE.
REQ-027 Minimum latency detect-to-release: detect N, ISSUE N+1 (ack+done), WB N+2 (ready), DONE N+3.
REQ-028 Outside detect/active states all outputs SHALL be 0.

Reset
REQ-029 rst low SHALL force IDLE asynchronously, including mid-operation; all outputs 0, captured regs 0, err 0, counter 0.
REQ-030 No accelerator abort SHALL be issued on reset; accelerator reset is the system's responsibility.

Configuration
REQ-031 Macro CNN_ISSUE_TIMEOUT_EN defined: counter cleared on entering ISSUE, increments each cycle in ISSUE/WAIT; reaching TIMEOUT_CYCLES without acc_done -> acc_abort=1 one cycle, wb_data=ERR_DATA, err set, go WB.
REQ-032 acc_done in the same cycle as expiry SHALL win (normal result, no abort, err unchanged).
REQ-033 err cleared only by reset.
REQ-034 Macro undefined: no counter logic; acc_abort and err tied 0; ports unchanged.

Structure
REQ-035 Shared package cnn_pkg SHALL hold OP_CNN (7'b0101011), FSM state typedef, TIMEOUT_CYCLES default, ERR_DATA default.
REQ-036 One sub-module cnn_timeout_cnt (clear/enable/expire), instantiated only under CNN_ISSUE_TIMEOUT_EN.

Verification
REQ-037 Op=0101011, RD1=5, RD2=7, RdD=3, ack N+1, done N+3 (result 35), ready immediate -> stall N..N+4, wb_rd=3 wb_data=35, DONE N+5 with FlushD=1.
REQ-038 acc_ack held low 4 cycles -> acc_req, acc_a, acc_b constant for those 4 cycles; no transition to WAIT.
REQ-039 RdD=0, done returns 9 -> wb_valid never asserted, DONE reached, stall released.
REQ-040 wb_ready low 3 cycles in WB -> wb_valid/wb_data held stable, StallD stays 1.
REQ-041 rst low while WAIT -> busy=0, StallD=0, acc_req=0 immediately; later acc_done ignored.
REQ-042 TIMEOUT_EN, TIMEOUT_CYCLES=8, no done -> acc_abort pulse after 8 ISSUE/WAIT cycles, wb_data=32'hFFFF_FFFF, err=1 until reset; repeat with done on expiry cycle -> err=0.
